// File: rtl/data_memory_interface_pkg.sv
// Shared constants for the data memory interface: RISC-V load/store funct3
// encodings and the access FSM state encoding.
`ifndef XLEN
`define XLEN 32
`endif

package data_memory_interface_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQUEST   = 2'd1,
      WAIT_RESP = 2'd2,
      COMPLETE  = 2'd3
   } memif_state_t;

endpackage

// File: rtl/data_memory_interface_load_store_aligner.sv
// Combinational lane steering for byte/half/word accesses: byte enables,
// replicated store data, load extraction with sign/zero extension, and
// illegal / misaligned classification.
// Optional: MISALIGNED_TRAP_EN enables misaligned detection; without it
// misaligned accesses are steered as if the low address bits were zero
// and o_misaligned is tied low.
module load_store_aligner
   import data_memory_interface_pkg::*;
(
   input  logic        i_write,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_write_data,
   input  logic [31:0] i_read_word,
   output logic [3:0]  o_byte_enable,
   output logic [31:0] o_lane_write_data,
   output logic [31:0] o_read_data,
   output logic        o_misaligned,
   output logic        o_illegal
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Legal encodings differ between loads and stores.
   always_comb begin
      o_illegal = 1'b0;
      if (i_write) begin
         o_illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
      end else begin
         o_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
      end
   end

   // Byte enables and store data by access size; lanes follow the address.
   always_comb begin
      o_byte_enable     = 4'b0000;
      o_lane_write_data = i_write_data;
      if (!o_illegal) begin
         case (i_funct3[1:0])
            2'b00: begin
               o_byte_enable     = 4'b0001 << i_addr;
               o_lane_write_data = {4{i_write_data[7:0]}};
            end
            2'b01: begin
               o_byte_enable     = 4'b0011 << {i_addr[1], 1'b0};
               o_lane_write_data = {2{i_write_data[15:0]}};
            end
            2'b10: begin
               o_byte_enable     = 4'b1111;
               o_lane_write_data = i_write_data;
            end
            default: begin
               o_byte_enable     = 4'b0000;
               o_lane_write_data = i_write_data;
            end
         endcase
      end
   end

   // Pick the addressed byte / halfword out of the raw read word.
   always_comb begin
      w_byte = i_read_word[7:0];
      case (i_addr)
         2'd0:    w_byte = i_read_word[7:0];
         2'd1:    w_byte = i_read_word[15:8];
         2'd2:    w_byte = i_read_word[23:16];
         default: w_byte = i_read_word[31:24];
      endcase
      w_half = i_addr[1] ? i_read_word[31:16] : i_read_word[15:0];
   end

   // Sign or zero extension of the selected load lane.
   always_comb begin
      o_read_data = 32'h0;
      case (i_funct3)
         FUNCT3_LB:  o_read_data = {{24{w_byte[7]}}, w_byte};
         FUNCT3_LBU: o_read_data = {24'h0, w_byte};
         FUNCT3_LH:  o_read_data = {{16{w_half[15]}}, w_half};
         FUNCT3_LHU: o_read_data = {16'h0, w_half};
         FUNCT3_LW:  o_read_data = i_read_word;
         default:    o_read_data = 32'h0;
      endcase
   end

   // Halfwords must be 2-byte aligned, words 4-byte aligned.
   always_comb begin
      o_misaligned = 1'b0;
`ifdef MISALIGNED_TRAP_EN
      if (!o_illegal) begin
         case (i_funct3[1:0])
            2'b01:   o_misaligned = i_addr[0];
            2'b10:   o_misaligned = (i_addr != 2'b00);
            default: o_misaligned = 1'b0;
         endcase
      end
`endif
   end

endmodule

// File: rtl/data_memory_interface.sv
// Data memory interface: turns the core's byte/half/word load/store into a
// single aligned word access over a valid/ready request and a response
// handshake, stalling the core until the access completes or times out.
// Optional: MISALIGNED_TRAP_EN traps misaligned accesses with
// misaligned_error instead of performing them at natural alignment.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no access; latch a new request when i_req_valid is high
// REQUEST   | o_mem_req_valid high, fields held until i_mem_req_ready
// WAIT_RESP | request accepted, waiting for i_mem_resp_valid or timeout
// COMPLETE  | one-cycle done pulse, result/error flags presented
`ifndef XLEN
`define XLEN 32
`endif

module data_memory_interface
   import data_memory_interface_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int XLEN           = `XLEN
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_req_valid,
   input  logic            i_req_write,
   input  logic [2:0]      i_req_funct3,
   input  logic [XLEN-1:0] i_req_address,
   input  logic [XLEN-1:0] i_req_write_data,
   output logic [XLEN-1:0] o_read_data,
   output logic            o_stall,
   output logic            o_done,
   output logic            o_bus_error,
   output logic            o_misaligned_error,
   output logic            o_mem_req_valid,
   input  logic            i_mem_req_ready,
   output logic [XLEN-1:0] o_mem_address,
   output logic            o_mem_write_enable,
   output logic [3:0]      o_mem_byte_enable,
   output logic [XLEN-1:0] o_mem_write_data,
   input  logic            i_mem_resp_valid,
   input  logic [XLEN-1:0] i_mem_resp_data
);

   localparam logic [1:0] S_IDLE      = IDLE;
   localparam logic [1:0] S_REQUEST   = REQUEST;
   localparam logic [1:0] S_WAIT_RESP = WAIT_RESP;
   localparam logic [1:0] S_COMPLETE  = COMPLETE;

   // Down-counter reloaded on request acceptance; reaching zero while still
   // waiting means TIMEOUT_CYCLES cycles were spent in WAIT_RESP.
   localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]      r_state;
   logic            r_write;
   logic [2:0]      r_funct3;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [CNT_W-1:0] r_timer;
   logic [XLEN-1:0] r_read_data;
   logic            r_bus_error;
`ifdef MISALIGNED_TRAP_EN
   logic            r_misaligned;
`endif

   logic            w_idle;
   logic            w_complete;
   logic            w_bus_active;
   logic            w_al_write;
   logic [2:0]      w_al_funct3;
   logic [1:0]      w_al_addr;
   logic [3:0]      w_byte_enable;
   logic [XLEN-1:0] w_lane_wdata;
   logic [XLEN-1:0] w_load_data;
   logic            w_misaligned;
   logic            w_illegal;

   assign w_idle       = (r_state == S_IDLE);
   assign w_complete   = (r_state == S_COMPLETE);
   assign w_bus_active = (r_state == S_REQUEST) || (r_state == S_WAIT_RESP);

   // In IDLE the aligner classifies the live request so illegal/misaligned
   // accesses can skip the bus; afterwards it works on the latched fields.
   assign w_al_write  = w_idle ? i_req_write       : r_write;
   assign w_al_funct3 = w_idle ? i_req_funct3      : r_funct3;
   assign w_al_addr   = w_idle ? i_req_address[1:0] : r_addr[1:0];

   load_store_aligner u_aligner (
      .i_write           (w_al_write),
      .i_funct3          (w_al_funct3),
      .i_addr            (w_al_addr),
      .i_write_data      (r_wdata),
      .i_read_word       (i_mem_resp_data),
      .o_byte_enable     (w_byte_enable),
      .o_lane_write_data (w_lane_wdata),
      .o_read_data       (w_load_data),
      .o_misaligned      (w_misaligned),
      .o_illegal         (w_illegal)
   );

   // Access FSM, request latch, timeout counter and result capture.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_write     <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_timer     <= '0;
         r_read_data <= '0;
         r_bus_error <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
         r_misaligned <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_timer     <= '0;
               r_read_data <= '0;
               r_bus_error <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
               r_misaligned <= 1'b0;
`endif
               if (i_req_valid) begin
                  r_write  <= i_req_write;
                  r_funct3 <= i_req_funct3;
                  r_addr   <= i_req_address;
                  r_wdata  <= i_req_write_data;
                  if (w_illegal) begin
                     r_bus_error <= 1'b1;
                     r_state     <= S_COMPLETE;
                  end else if (w_misaligned) begin
`ifdef MISALIGNED_TRAP_EN
                     r_misaligned <= 1'b1;
`endif
                     r_state <= S_COMPLETE;
                  end else begin
                     r_state <= S_REQUEST;
                  end
               end
            end
            S_REQUEST: begin
               if (i_mem_req_ready) begin
                  r_timer <= TIMER_LOAD;
                  r_state <= S_WAIT_RESP;
               end
            end
            S_WAIT_RESP: begin
               if (i_mem_resp_valid) begin
                  r_read_data <= r_write ? '0 : w_load_data;
                  r_state     <= S_COMPLETE;
               end else if (r_timer == '0) begin
                  r_read_data <= '0;
                  r_bus_error <= 1'b1;
                  r_state     <= S_COMPLETE;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            S_COMPLETE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_stall     = i_req_valid && !w_complete;
   assign o_done      = w_complete;
   assign o_read_data = w_complete ? r_read_data : '0;
   assign o_bus_error = w_complete && r_bus_error;
`ifdef MISALIGNED_TRAP_EN
   assign o_misaligned_error = w_complete && r_misaligned;
`else
   assign o_misaligned_error = 1'b0;
`endif

   // Bus fields come from the latched request and are quiet outside an access.
   assign o_mem_req_valid    = (r_state == S_REQUEST);
   assign o_mem_address      = w_bus_active ? {r_addr[XLEN-1:2], 2'b00} : '0;
   assign o_mem_write_enable = w_bus_active && r_write;
   assign o_mem_byte_enable  = w_bus_active ? w_byte_enable : 4'b0000;
   assign o_mem_write_data   = w_bus_active ? w_lane_wdata : '0;

endmodule

// File: tb/tb_data_memory_interface.sv
// Directed bench for data_memory_interface with a cycle-driven memory model
// (configurable ready and response latency). TIMEOUT_CYCLES is set to 8.
module tb_data_memory_interface;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_address;
   logic [31:0] req_write_data;
   logic [31:0] read_data;
   logic        stall;
   logic        done;
   logic        bus_error;
   logic        misaligned_error;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_address;
   logic        mem_write_enable;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_write_data;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   always #5 clock = ~clock;

   data_memory_interface #(.TIMEOUT_CYCLES(8)) dut (
      .i_clock            (clock),
      .i_reset            (reset),
      .i_req_valid        (req_valid),
      .i_req_write        (req_write),
      .i_req_funct3       (req_funct3),
      .i_req_address      (req_address),
      .i_req_write_data   (req_write_data),
      .o_read_data        (read_data),
      .o_stall            (stall),
      .o_done             (done),
      .o_bus_error        (bus_error),
      .o_misaligned_error (misaligned_error),
      .o_mem_req_valid    (mem_req_valid),
      .i_mem_req_ready    (mem_req_ready),
      .o_mem_address      (mem_address),
      .o_mem_write_enable (mem_write_enable),
      .o_mem_byte_enable  (mem_byte_enable),
      .o_mem_write_data   (mem_write_data),
      .i_mem_resp_valid   (mem_resp_valid),
      .i_mem_resp_data    (mem_resp_data)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   int          res_done_cyc;
   int          res_done_cnt;
   logic [31:0] res_rd;
   logic        res_berr;
   logic        res_mis;
   logic [15:0] res_stall;
   logic        res_saw_req;
   logic        res_moved;
   logic [31:0] res_addr;
   logic [31:0] res_wd;
   logic [3:0]  res_be;
   logic        res_we;

   // One access, starting and ending at a falling edge. The memory model
   // raises ready after rdy_lat request cycles and answers rsp_lat cycles
   // after the acceptance cycle's successor (0 = immediately).
   task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rsp,
                             input int rdy_lat, input int rsp_lat, input bit never);
      int cyc = 0;
      int rdy_cnt = 0;
      int rsp_cnt = 0;
      bit accepted = 0;
      bit rsp_given = 0;
      bit seen_done = 0;
      bit first_req = 0;
      res_done_cyc = -1;
      res_done_cnt = 0;
      res_rd = 32'hx;
      res_berr = 1'bx;
      res_mis = 1'bx;
      res_stall = 16'h0;
      res_saw_req = 1'b0;
      res_moved = 1'b0;
      res_addr = 32'h0;
      res_wd = 32'h0;
      res_be = 4'h0;
      res_we = 1'b0;
      req_write = wr;
      req_funct3 = f3;
      req_address = addr;
      req_write_data = wd;
      req_valid = 1'b1;
      while (!seen_done && cyc < 200) begin
         if (accepted && !rsp_given && !never) begin
            if (rsp_cnt == rsp_lat) begin
               mem_resp_valid = 1'b1;
               mem_resp_data = rsp;
               rsp_given = 1;
            end else begin
               mem_resp_valid = 1'b0;
               rsp_cnt++;
            end
         end else begin
            mem_resp_valid = 1'b0;
         end
         if (mem_req_valid && !accepted) begin
            if (rdy_cnt == rdy_lat) begin
               mem_req_ready = 1'b1;
               accepted = 1;
            end else begin
               mem_req_ready = 1'b0;
               rdy_cnt++;
            end
         end else begin
            mem_req_ready = 1'b0;
         end
         if (mem_req_valid) begin
            if (!first_req) begin
               first_req = 1;
               res_addr = mem_address;
               res_wd = mem_write_data;
               res_be = mem_byte_enable;
               res_we = mem_write_enable;
            end else if (mem_address !== res_addr || mem_write_data !== res_wd ||
                         mem_byte_enable !== res_be || mem_write_enable !== res_we) begin
               res_moved = 1'b1;
            end
         end
         #1;
         if (cyc < 16) res_stall[cyc] = stall;
         if (mem_req_valid) res_saw_req = 1'b1;
         if (done) begin
            seen_done = 1;
            res_done_cnt++;
            res_done_cyc = cyc;
            res_rd = read_data;
            res_berr = bus_error;
            res_mis = misaligned_error;
         end
         @(negedge clock);
         cyc++;
      end
      if (!seen_done) check("done_within_budget", 32'd0, 32'd1);
      req_valid = 1'b0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (done) res_done_cnt++;
         @(negedge clock);
      end
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_funct3 = 3'b000;
      req_address = 32'h0;
      req_write_data = 32'h0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data = 32'h0;
      repeat (3) @(negedge clock);
      #1;
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_stall", {31'h0, stall}, 32'd0);
      check("rst_read_data", read_data, 32'h0);
      check("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'd0);
      check("rst_byte_enable", {28'h0, mem_byte_enable}, 32'h0);
      check("rst_bus_error", {31'h0, bus_error}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // SW, zero-wait memory
      run_access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
      check("sw_addr", res_addr, 32'h0000_0100);
      check("sw_be", {28'h0, res_be}, 32'hF);
      check("sw_we", {31'h0, res_we}, 32'd1);
      check("sw_wdata", res_wd, 32'hDEAD_BEEF);
      check("sw_done_cycle", res_done_cyc, 32'd3);
      check("sw_stall_cycles", {16'h0, res_stall}, 32'h0007);
      check("sw_done_count", res_done_cnt, 32'd1);
      check("sw_bus_error", {31'h0, res_berr}, 32'd0);

      // LB / LBU at byte 3
      run_access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80AA_BBCC, 0, 0, 0);
      check("lb_rd", res_rd, 32'hFFFF_FF80);
      check("lb_be", {28'h0, res_be}, 32'h8);
      check("lb_we", {31'h0, res_we}, 32'd0);
      check("lb_addr", res_addr, 32'h0000_0200);
      run_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80AA_BBCC, 0, 0, 0);
      check("lbu_rd", res_rd, 32'h0000_0080);

      // SH / LHU / LH upper and lower halves
      run_access(1'b1, 3'b001, 32'h0000_0302, 32'h0000_1234, 32'h0, 0, 0, 0);
      check("sh_be", {28'h0, res_be}, 32'hC);
      check("sh_wdata", res_wd, 32'h1234_1234);
      run_access(1'b0, 3'b101, 32'h0000_0302, 32'h0, 32'hBEEF_0000, 0, 0, 0);
      check("lhu_rd", res_rd, 32'h0000_BEEF);
      run_access(1'b0, 3'b001, 32'h0000_0300, 32'h0, 32'h1234_8765, 0, 0, 0);
      check("lh_rd", res_rd, 32'hFFFF_8765);
      check("lh_be", {28'h0, res_be}, 32'h3);

      // SB at byte 1
      run_access(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0, 0, 0);
      check("sb_be", {28'h0, res_be}, 32'h2);
      check("sb_wdata", res_wd, 32'hABAB_ABAB);

      // Back-pressure: ready low 5 cycles, response 3 cycles after acceptance
      run_access(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 5, 2, 0);
      check("bp_done_cycle", res_done_cyc, 32'd10);
      check("bp_stall_cycles", {16'h0, res_stall}, 32'h03FF);
      check("bp_fields_stable", {31'h0, res_moved}, 32'd0);
      check("bp_done_count", res_done_cnt, 32'd1);
      check("bp_rd", res_rd, 32'hCAFE_F00D);

      // Memory never responds: timeout after 8 WAIT_RESP cycles
      run_access(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0, 0, 0, 1);
      check("to_done_cycle", res_done_cyc, 32'd10);
      check("to_bus_error", {31'h0, res_berr}, 32'd1);
      check("to_rd", res_rd, 32'h0);
      check("to_done_count", res_done_cnt, 32'd1);

      // Illegal funct3: no request, straight to completion with bus_error
      run_access(1'b0, 3'b011, 32'h0000_0700, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
      check("ill_ld_done_cycle", res_done_cyc, 32'd1);
      check("ill_ld_no_req", {31'h0, res_saw_req}, 32'd0);
      check("ill_ld_bus_error", {31'h0, res_berr}, 32'd1);
      check("ill_ld_rd", res_rd, 32'h0);
      check("ill_ld_stall", {16'h0, res_stall}, 32'h0001);
      run_access(1'b1, 3'b100, 32'h0000_0700, 32'h5555_5555, 32'h0, 0, 0, 0);
      check("ill_st_no_req", {31'h0, res_saw_req}, 32'd0);
      check("ill_st_bus_error", {31'h0, res_berr}, 32'd1);

      // Misaligned LW
      run_access(1'b0, 3'b010, 32'h0000_0401, 32'h0, 32'h1122_3344, 0, 0, 0);
`ifdef MISALIGNED_TRAP_EN
      check("mis_done_cycle", res_done_cyc, 32'd1);
      check("mis_no_req", {31'h0, res_saw_req}, 32'd0);
      check("mis_flag", {31'h0, res_mis}, 32'd1);
      check("mis_rd", res_rd, 32'h0);
      check("mis_bus_error", {31'h0, res_berr}, 32'd0);
`else
      check("mis_done_cycle", res_done_cyc, 32'd3);
      check("mis_addr", res_addr, 32'h0000_0400);
      check("mis_be", {28'h0, res_be}, 32'hF);
      check("mis_rd", res_rd, 32'h1122_3344);
      check("mis_flag", {31'h0, res_mis}, 32'd0);
`endif

      // Reset dropped mid-REQUEST, then a late response in IDLE
      req_write = 1'b0;
      req_funct3 = 3'b010;
      req_address = 32'h0000_0800;
      req_valid = 1'b1;
      mem_req_ready = 1'b0;
      @(negedge clock);
      #1;
      check("rst_mid_req_active", {31'h0, mem_req_valid}, 32'd1);
      reset = 1'b0;
      req_valid = 1'b0;
      @(negedge clock);
      #1;
      check("rst_mid_req_dropped", {31'h0, mem_req_valid}, 32'd0);
      check("rst_mid_no_done", {31'h0, done}, 32'd0);
      reset = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'h1234_5678;
      @(negedge clock);
      #1;
      check("late_resp_no_done", {31'h0, done}, 32'd0);
      check("late_resp_no_req", {31'h0, mem_req_valid}, 32'd0);
      mem_resp_valid = 1'b0;
      @(negedge clock);
      #1;
      check("late_resp_idle_done", {31'h0, done}, 32'd0);
      @(negedge clock);

      // Normal access after the reset
      run_access(1'b0, 3'b100, 32'h0000_0901, 32'h0, 32'h0000_7F00, 0, 0, 0);
      check("post_rst_done_cycle", res_done_cyc, 32'd3);
      check("post_rst_rd", res_rd, 32'h0000_007F);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
